// File: rtl/lc4_regfile_writer_pkg.sv
// Common LC4 register-file constants shared by the writeback queue and its front end.
package lc4_regfile_writer_pkg;

   localparam int NUM_REGS  = 8;
   localparam int REG_IDX_W = 3;

   // Occupancy counters need one more bit than the pointers to represent "full".
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/lc4_regfile_writer_wbq_fifo.sv
// Writeback queue storage: circular buffer with head/tail pointers and occupancy count.
module lc4_wbq_fifo
   import lc4_regfile_writer_pkg::*;
#(
   parameter int n     = 16,
   parameter int DEPTH = 4
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 push,
   input  logic                                 pop,
   input  logic [REG_IDX_W-1:0]                 push_rd,
   input  logic [n-1:0]                         push_data,
   output logic                                 full,
   output logic                                 empty,
   output logic [cnt_w(DEPTH)-1:0]              count,
   output logic [$clog2(DEPTH)-1:0]             head_ptr,
   output logic [REG_IDX_W-1:0]                 head_rd,
   output logic [n-1:0]                         head_data,
   output logic [DEPTH-1:0][REG_IDX_W-1:0]      ent_rd,
   output logic [DEPTH-1:0][n-1:0]              ent_data,
   output logic [DEPTH-1:0]                     ent_valid
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [DEPTH-1:0][REG_IDX_W-1:0] mem_rd;
   logic [DEPTH-1:0][n-1:0]         mem_data;
   logic [PW-1:0]                   head;
   logic [PW-1:0]                   tail;
   logic [CW-1:0]                   occ;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head     <= '0;
         tail     <= '0;
         occ      <= '0;
         mem_rd   <= '0;
         mem_data <= '0;
      end else begin
         if (push) begin
            mem_rd[tail]   <= push_rd;
            mem_data[tail] <= push_data;
            tail           <= tail + 1'b1;
         end
         if (pop) begin
            head <= head + 1'b1;
         end
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   assign full      = (occ == CW'(DEPTH));
   assign empty     = (occ == '0);
   assign count     = occ;
   assign head_ptr  = head;
   assign head_rd   = mem_rd[head];
   assign head_data = mem_data[head];
   assign ent_rd    = mem_rd;
   assign ent_data  = mem_data;

   // A slot is live when its distance from the head (mod DEPTH) is below the occupancy.
   always_comb begin
      ent_valid = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ent_valid[i] = ({1'b0, PW'(i) - head} < occ);
      end
   end

endmodule

// File: rtl/lc4_regfile_writer.sv
// LC4 register-file write front end: in-order writeback queue with busy mask and forwarding.
module lc4_regfile_writer
   import lc4_regfile_writer_pkg::*;
#(
   parameter int n     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     gwe,
   input  logic                     i_enq_valid,
   output logic                     o_enq_ready,
   input  logic [REG_IDX_W-1:0]     i_enq_rd,
   input  logic [n-1:0]             i_enq_data,
   input  logic                     i_drain_en,
   output logic [REG_IDX_W-1:0]     o_rd,
   output logic [n-1:0]             o_wdata,
   output logic                     o_rd_we,
   output logic [cnt_w(DEPTH)-1:0]  o_count,
   output logic [NUM_REGS-1:0]      o_busy,
   input  logic [REG_IDX_W-1:0]     i_lookup_rs,
   output logic                     o_fwd_hit,
   output logic [n-1:0]             o_fwd_data
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic                             full;
   logic                             empty;
   logic                             push;
   logic                             pop;
   logic [PW-1:0]                    head_ptr;
   logic [REG_IDX_W-1:0]             head_rd;
   logic [DEPTH-1:0][REG_IDX_W-1:0]  ent_rd;
   logic [DEPTH-1:0][n-1:0]          ent_data;
   logic [DEPTH-1:0]                 ent_valid;
   logic [NUM_REGS-1:0][CW-1:0]      pend;

   // Full blocks enqueue even when a drain fires this cycle.
   assign push        = gwe & i_enq_valid & ~full;
   assign pop         = gwe & i_drain_en & ~empty;
   assign o_enq_ready = ~full;
   assign o_rd_we     = pop;
   assign o_rd        = head_rd;

   lc4_wbq_fifo #(
      .n     (n),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_rd   (i_enq_rd),
      .push_data (i_enq_data),
      .full      (full),
      .empty     (empty),
      .count     (o_count),
      .head_ptr  (head_ptr),
      .head_rd   (head_rd),
      .head_data (o_wdata),
      .ent_rd    (ent_rd),
      .ent_data  (ent_data),
      .ent_valid (ent_valid)
   );

   // Per-register pending counters; same rd entering and leaving cancels out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend <= '0;
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            case ({push && (i_enq_rd == REG_IDX_W'(r)), pop && (head_rd == REG_IDX_W'(r))})
               2'b10:   pend[r] <= pend[r] + 1'b1;
               2'b01:   pend[r] <= pend[r] - 1'b1;
               default: pend[r] <= pend[r];
            endcase
         end
      end
   end

   always_comb begin
      o_busy = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         o_busy[r] = (pend[r] != '0);
      end
   end

   // Scan oldest to youngest so the last match (closest to tail) wins.
   always_comb begin
      logic [PW-1:0] idx;
      idx        = '0;
      o_fwd_hit  = 1'b0;
      o_fwd_data = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = head_ptr + PW'(k);
         if (ent_valid[idx] && (ent_rd[idx] == i_lookup_rs)) begin
            o_fwd_hit  = 1'b1;
            o_fwd_data = ent_data[idx];
         end
      end
   end

endmodule

// File: tb/tb_lc4_regfile_writer.sv
// Directed and randomized checks of lc4_regfile_writer against a queue-based reference model.
module tb_lc4_regfile_writer;

   localparam int DEPTH = 4;

   typedef struct {
      logic [2:0]  rd;
      logic [15:0] data;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        gwe = 1'b0;
   logic        i_enq_valid = 1'b0;
   logic        o_enq_ready;
   logic [2:0]  i_enq_rd = '0;
   logic [15:0] i_enq_data = '0;
   logic        i_drain_en = 1'b0;
   logic [2:0]  o_rd;
   logic [15:0] o_wdata;
   logic        o_rd_we;
   logic [2:0]  o_count;
   logic [7:0]  o_busy;
   logic [2:0]  i_lookup_rs = '0;
   logic        o_fwd_hit;
   logic [15:0] o_fwd_data;

   int n_checks = 0;
   int n_fail   = 0;
   wb_t q[$];

   lc4_regfile_writer #(.n(16), .DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .gwe         (gwe),
      .i_enq_valid (i_enq_valid),
      .o_enq_ready (o_enq_ready),
      .i_enq_rd    (i_enq_rd),
      .i_enq_data  (i_enq_data),
      .i_drain_en  (i_drain_en),
      .o_rd        (o_rd),
      .o_wdata     (o_wdata),
      .o_rd_we     (o_rd_we),
      .o_count     (o_count),
      .o_busy      (o_busy),
      .i_lookup_rs (i_lookup_rs),
      .o_fwd_hit   (o_fwd_hit),
      .o_fwd_data  (o_fwd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic g, input logic v, input logic [2:0] rd,
                        input logic [15:0] d, input logic dr, input logic [2:0] lk);
      @(negedge clk);
      gwe = g; i_enq_valid = v; i_enq_rd = rd; i_enq_data = d;
      i_drain_en = dr; i_lookup_rs = lk;
      #1;
   endtask

   // Expected outputs derived directly from the queue contents.
   task automatic check_model();
      logic [7:0]  busy = '0;
      logic        hit  = 1'b0;
      logic [15:0] fd   = '0;
      int          sz   = q.size();
      foreach (q[i]) begin
         busy[q[i].rd] = 1'b1;
         if (q[i].rd == i_lookup_rs) begin
            hit = 1'b1;
            fd  = q[i].data;
         end
      end
      chk("count", 32'(o_count), 32'(sz));
      chk("enq_ready", 32'(o_enq_ready), 32'(sz < DEPTH));
      chk("rd_we", 32'(o_rd_we), 32'(gwe && i_drain_en && sz > 0));
      if (sz > 0) begin
         chk("head_rd", 32'(o_rd), 32'(q[0].rd));
         chk("head_wdata", 32'(o_wdata), 32'(q[0].data));
      end
      chk("busy", 32'(o_busy), 32'(busy));
      chk("fwd_hit", 32'(o_fwd_hit), 32'(hit));
      chk("fwd_data", 32'(o_fwd_data), 32'(fd));
   endtask

   task automatic tick();
      bit  enq = gwe && i_enq_valid && (q.size() < DEPTH);
      bit  deq = gwe && i_drain_en && (q.size() > 0);
      wb_t e;
      e.rd = i_enq_rd;
      e.data = i_enq_data;
      @(posedge clk);
      if (deq) void'(q.pop_front());
      if (enq) q.push_back(e);
   endtask

   task automatic step(input logic g, input logic v, input logic [2:0] rd,
                       input logic [15:0] d, input logic dr, input logic [2:0] lk);
      drive(g, v, rd, d, dr, lk);
      check_model();
      tick();
   endtask

   task automatic check_cleared(input string tag);
      chk({tag, "_count"}, 32'(o_count), 0);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_ready"}, 32'(o_enq_ready), 1);
      chk({tag, "_rd_we"}, 32'(o_rd_we), 0);
      chk({tag, "_rd"}, 32'(o_rd), 0);
      chk({tag, "_wdata"}, 32'(o_wdata), 0);
      chk({tag, "_fwd_hit"}, 32'(o_fwd_hit), 0);
      chk({tag, "_fwd_data"}, 32'(o_fwd_data), 0);
   endtask

   initial begin
      // Reset, then idle with drain requested
      i_drain_en = 1'b1;
      gwe = 1'b1;
      #3;
      check_cleared("reset");
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);

      // Single request, then drain it the following cycle
      step(1, 1, 3, 16'h1234, 0, 3);
      drive(1, 0, 0, 0, 1, 3);
      check_model();
      chk("single_rd", 32'(o_rd), 3);
      chk("single_wdata", 32'(o_wdata), 32'h1234);
      chk("single_we", 32'(o_rd_we), 1);
      chk("single_busy_before", 32'(o_busy), 32'h08);
      tick();
      drive(1, 0, 0, 0, 0, 3);
      chk("single_busy_after", 32'(o_busy), 0);
      check_model();
      tick();

      // Two writes to R1: youngest forwards, drains in order
      step(1, 1, 1, 16'hAAAA, 0, 1);
      step(1, 1, 1, 16'hBBBB, 0, 1);
      drive(1, 0, 0, 0, 0, 1);
      chk("fwd2_hit", 32'(o_fwd_hit), 1);
      chk("fwd2_data", 32'(o_fwd_data), 32'hBBBB);
      chk("fwd2_busy", 32'(o_busy), 32'h02);
      check_model();
      tick();
      drive(1, 0, 0, 0, 1, 1);
      chk("order_first", 32'(o_wdata), 32'hAAAA);
      chk("drain_head_hit", 32'(o_fwd_data), 32'hBBBB);
      check_model();
      tick();
      drive(1, 0, 0, 0, 1, 1);
      chk("order_second", 32'(o_wdata), 32'hBBBB);
      chk("drain_last_hit", 32'(o_fwd_hit), 1);
      check_model();
      tick();

      // Fill, then enqueue against a full queue while draining
      for (int r = 0; r < DEPTH; r++) step(1, 1, 3'(r), 16'(16'h100 + r), 0, 2);
      drive(1, 1, 7, 16'h7777, 1, 7);
      chk("full_ready", 32'(o_enq_ready), 0);
      chk("full_count", 32'(o_count), 4);
      check_model();
      tick();
      drive(1, 1, 7, 16'h7777, 1, 7);
      chk("after_full_count", 32'(o_count), 3);
      chk("after_full_fwd", 32'(o_fwd_hit), 0);
      check_model();
      tick();
      drive(1, 0, 0, 0, 0, 7);
      chk("enq_drain_count", 32'(o_count), 3);
      chk("r7_fwd", 32'(o_fwd_data), 32'h7777);
      check_model();
      tick();

      // gwe low freezes everything
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 5, 16'h5555, 1, 5);
         chk("gwe0_we", 32'(o_rd_we), 0);
         chk("gwe0_count", 32'(o_count), 3);
         check_model();
         tick();
      end

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 7) != 0, $urandom_range(0, 1), 3'($urandom_range(0, 7)),
              16'($urandom), $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)));
      end

      // Async reset mid-cycle with 3 entries queued
      while (q.size() > 0) step(1, 0, 0, 0, 1, 0);
      for (int r = 0; r < 3; r++) step(1, 1, 3'(r + 4), 16'(16'hC00 + r), 0, 5);
      drive(1, 0, 0, 0, 1, 5);
      #2;
      rst = 1'b0;
      #1;
      check_cleared("async_rst");
      q.delete();
      @(negedge clk);
      #2;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 0, 1, 5);
         chk("post_rst_we", 32'(o_rd_we), 0);
         check_model();
         tick();
      end
      step(1, 1, 6, 16'hD00D, 0, 6);
      step(1, 0, 0, 0, 1, 6);
      step(1, 0, 0, 0, 1, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
